// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical RV32I NOP (addi x0, x0, 0) shown to ID when idle
//   fetch_entry_t : one buffered fetch {pc, instr}
//   word_align    : clears the two low address bits of a fetch target
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch_entry_t, used both as the prefetch buffer
// and as the pc-tag queue for requests still owed by memory.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i at the tail
//   pop_i         : drop the head entry (caller guarantees non-empty)
//   flush_i       : empty the queue this cycle; overrides push and pop
//   head_o        : current head entry (stale when count_o is zero)
//   count_o       : number of valid entries, 0..DEPTH
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output fetch_entry_t head_o,
   output logic [CW-1:0] count_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   // Pointer, count and entry storage registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generator, ready/valid memory port,
// in-order prefetch buffer, ID stall back-pressure and redirect/flush.
//   clk, reset (async, active-low)
//   imem_req_valid/addr/ready : request port (addr held while not accepted)
//   imem_rsp_valid/data       : in-order response port, at most one per cycle
//   redirect, redirect_pc     : one-cycle control-flow change from EX
//   id_ready                  : ID accepts the presented instruction
//   id_valid/instr/pc/pcplus4 : head of the prefetch buffer toward IF/ID
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            id_valid,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pcplus4
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam int OW = CW + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] last_pc_q, last_pc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   discard_q, discard_d;

   fetch_entry_t    buf_head_s, buf_push_s, tag_head_s, tag_push_s;
   logic [CW-1:0]   buf_count_s, tag_count_s;
   logic [OW-1:0]   occupancy_s;
   logic            valid_s, pop_s, req_valid_s, accept_s;
   logic            rsp_live_s, drop_s, deliver_s;

   // Issue credit, response routing and next-state for pc and counters.
   always_comb begin
      valid_s     = (buf_count_s != '0);
      pop_s       = valid_s & id_ready & ~redirect;
      // Buffered plus owed words, after this cycle's pop, must leave a free slot.
      occupancy_s = OW'(buf_count_s) + OW'(inflight_q) - OW'(pop_s);
      req_valid_s = reset & ~redirect & (occupancy_s < OW'(BUF_DEPTH));
      accept_s    = req_valid_s & imem_req_ready;
      // A word with nothing outstanding is stale (e.g. issued before reset).
      rsp_live_s  = imem_rsp_valid & (inflight_q != '0);
      drop_s      = rsp_live_s & (discard_q != '0);
      deliver_s   = rsp_live_s & (discard_q == '0) & (tag_count_s != '0) & ~redirect;

      tag_push_s       = '{pc: pc_q, instr: NOP_INSTR};
      buf_push_s       = tag_head_s;
      buf_push_s.instr = imem_rsp_data;

      inflight_d = inflight_q + CW'(accept_s) - CW'(rsp_live_s);

      if (redirect) begin
         // Every word still owed after this cycle belongs to the old path.
         discard_d = inflight_q - CW'(rsp_live_s);
      end else if (drop_s) begin
         discard_d = discard_q - CW'(1'b1);
      end else begin
         discard_d = discard_q;
      end

      if (redirect) begin
         pc_d = word_align(redirect_pc);
      end else if (accept_s) begin
         pc_d = pc_q + 32'd4;
      end else begin
         pc_d = pc_q;
      end

      if (pop_s) begin
         last_pc_d = buf_head_s.pc;
      end else begin
         last_pc_d = last_pc_q;
      end
   end

   // Fetch pc, last consumed pc and in-flight / discard counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         last_pc_q  <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         pc_q       <= pc_d;
         last_pc_q  <= last_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   fetch_fifo #(.DEPTH(BUF_DEPTH)) u_tag_q (
      .clk_i       (clk),
      .rst_ni      (reset),
      .push_i      (accept_s),
      .push_data_i (tag_push_s),
      .pop_i       (deliver_s),
      .flush_i     (redirect),
      .head_o      (tag_head_s),
      .count_o     (tag_count_s)
   );

   fetch_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk_i       (clk),
      .rst_ni      (reset),
      .push_i      (deliver_s),
      .push_data_i (buf_push_s),
      .pop_i       (pop_s),
      .flush_i     (redirect),
      .head_o      (buf_head_s),
      .count_o     (buf_count_s)
   );

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = pc_q;
   assign id_valid       = valid_s;
   assign id_instr       = valid_s ? buf_head_s.instr : NOP_INSTR;
   assign id_pc          = valid_s ? buf_head_s.pc : last_pc_q;
   assign id_pcplus4     = id_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable memory model and
// an instruction-stream reference (expected pc sequence, buffered word count).
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int          D   = 2;
   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid, redirect, id_ready, id_valid;
   logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, id_instr, id_pc, id_pcplus4;

   fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(D)) dut (
      .clk(clk), .reset(reset),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
      .id_pc(id_pc), .id_pcplus4(id_pcplus4)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int npops = 0;

   // memory model: queue of accepted requests with due cycle and path epoch
   logic [31:0] mq_addr[$];
   int          mq_due[$];
   int          mq_epoch[$];
   int lat = 1, rdy_pct = 100, idr_pct = 100;

   // reference stream state
   int          epoch = 0;
   int          buf_model = 0;
   logic [31:0] exp_pop_pc = RPC, exp_fetch_pc = RPC;
   logic        hold_pend = 1'b0;
   logic [31:0] hold_addr = 32'h0;
   logic        do_redirect = 1'b0;
   logic [31:0] redir_target = 32'h0;

   // observations of the last cycle
   logic        s_pop, s_valid, s_acc, s_req;
   logic [31:0] s_pop_pc;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic cycle();
      int   occ;
      int   ep;
      logic pop_m, exp_req;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      id_ready       = ($urandom_range(99) < idr_pct);
      redirect       = do_redirect;
      redirect_pc    = redir_target;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = memfn(mq_addr[0]);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      #1;
      occ     = mq_addr.size() + buf_model;
      pop_m   = (buf_model != 0) && id_ready && !redirect;
      exp_req = !redirect && ((occ - int'(pop_m)) < D);

      checks++;
      if (id_valid !== (buf_model != 0)) begin
         errors++; $display("FAIL id_valid cyc %0d: got %0b want %0b", cyc, id_valid, buf_model != 0);
      end
      if (buf_model != 0) begin
         checks++;
         if (id_pc !== exp_pop_pc || id_instr !== memfn(exp_pop_pc) || id_pcplus4 !== exp_pop_pc + 32'd4) begin
            errors++; $display("FAIL id_entry cyc %0d: got pc %h instr %h pc4 %h want pc %h instr %h", cyc,
                               id_pc, id_instr, id_pcplus4, exp_pop_pc, memfn(exp_pop_pc));
         end
      end else begin
         checks++;
         if (id_instr !== NOP_INSTR) begin
            errors++; $display("FAIL idle_nop cyc %0d: got %h want %h", cyc, id_instr, NOP_INSTR);
         end
      end
      checks++;
      if (imem_req_valid !== exp_req) begin
         errors++; $display("FAIL req_valid cyc %0d: got %0b want %0b", cyc, imem_req_valid, exp_req);
      end
      if (imem_req_valid === 1'b1) begin
         checks++;
         if (imem_req_addr !== exp_fetch_pc) begin
            errors++; $display("FAIL req_addr cyc %0d: got %h want %h", cyc, imem_req_addr, exp_fetch_pc);
         end
      end
      if (hold_pend && !redirect) begin
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== hold_addr) begin
            errors++; $display("FAIL req_hold cyc %0d: got v%0b %h want v1 %h", cyc, imem_req_valid, imem_req_addr, hold_addr);
         end
      end
      checks++;
      if (occ > D) begin
         errors++; $display("FAIL credit cyc %0d: got %0d outstanding+buffered want <= %0d", cyc, occ, D);
      end

      s_acc    = imem_req_valid & imem_req_ready;
      s_req    = imem_req_valid;
      s_valid  = id_valid;
      s_pop    = id_valid & id_ready & ~redirect;
      s_pop_pc = id_pc;

      if (imem_rsp_valid) begin
         ep = mq_epoch.pop_front();
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
         if (ep == epoch && !redirect) buf_model++;
      end
      if (pop_m) begin
         buf_model--;
         exp_pop_pc = exp_pop_pc + 32'd4;
         npops++;
      end
      hold_pend = imem_req_valid & ~imem_req_ready & ~redirect;
      hold_addr = imem_req_addr;
      if (s_acc) begin
         mq_addr.push_back(imem_req_addr);
         mq_due.push_back(cyc + lat);
         mq_epoch.push_back(epoch);
         exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (redirect) begin
         epoch++;
         buf_model    = 0;
         exp_pop_pc   = {redir_target[31:2], 2'b00};
         exp_fetch_pc = {redir_target[31:2], 2'b00};
      end
      do_redirect = 1'b0;
      @(negedge clk);
      cyc++;
   endtask

   task automatic test_reset();
      reset = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP_INSTR ||
          id_pc !== 32'h0 || id_pcplus4 !== 32'h4) begin
         errors++; $display("FAIL reset_vals: got rv%0b iv%0b %h %h %h want 0 0 %h 0 4",
                            imem_req_valid, id_valid, id_instr, id_pc, id_pcplus4, NOP_INSTR);
      end
      reset = 1'b1; #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
         errors++; $display("FAIL first_req: got v%0b %h want v1 %h", imem_req_valid, imem_req_addr, RPC);
      end
   endtask

   task automatic test_stream();
      int fa = -1, fv = -1, n0 = npops, c;
      lat = 1; rdy_pct = 100; idr_pct = 100;
      for (int i = 0; i < 20; i++) begin
         c = cyc;
         cycle();
         if (s_acc && fa < 0) fa = c;
         if (s_valid && fv < 0) fv = c;
      end
      checks++;
      if (fa < 0 || fv - fa != 2) begin
         errors++; $display("FAIL latency: got %0d cycles want 2", fv - fa);
      end
      checks++;
      if (npops - n0 != 18) begin
         errors++; $display("FAIL throughput: got %0d pops want 18", npops - n0);
      end
   endtask

   task automatic test_stall();
      int n0;
      lat = 1; rdy_pct = 100; idr_pct = 100;
      for (int i = 0; i < 4; i++) cycle();
      idr_pct = 0;
      for (int i = 0; i < 5; i++) cycle();
      checks++;
      if (s_req !== 1'b0 || s_valid !== 1'b1) begin
         errors++; $display("FAIL stall_full: got req %0b valid %0b want 0 1", s_req, s_valid);
      end
      n0 = npops;
      idr_pct = 100;
      for (int i = 0; i < 8; i++) cycle();
      checks++;
      if (npops - n0 < 6) begin
         errors++; $display("FAIL stall_resume: got %0d pops want >= 6", npops - n0);
      end
   endtask

   task automatic test_slow_mem();
      int n0 = npops;
      lat = 3; rdy_pct = 50; idr_pct = 75;
      for (int i = 0; i < 200; i++) cycle();
      checks++;
      if (npops - n0 < 20) begin
         errors++; $display("FAIL slow_progress: got %0d pops want >= 20", npops - n0);
      end
   endtask

   task automatic test_redirect_inflight();
      int  accs = 0;
      logic found = 1'b0;
      lat = 3; rdy_pct = 0; idr_pct = 100;
      for (int i = 0; i < 8; i++) cycle();
      checks++;
      if (s_valid !== 1'b0) begin
         errors++; $display("FAIL drain: got id_valid %0b want 0", s_valid);
      end
      rdy_pct = 100;
      for (int i = 0; i < 2; i++) begin cycle(); if (s_acc) accs++; end
      checks++;
      if (accs != 2) begin
         errors++; $display("FAIL two_inflight: got %0d accepts want 2", accs);
      end
      do_redirect = 1'b1; redir_target = 32'h0000_0103;
      cycle();
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (s_pop) begin
            found = 1'b1;
            checks++;
            if (s_pop_pc !== 32'h0000_0100) begin
               errors++; $display("FAIL redir_target: got %h want 00000100", s_pop_pc);
            end
         end
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL redir_timeout: got no pop want one");
      end
   endtask

   task automatic wait_first_pop(input logic [31:0] want);
      logic found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         cycle();
         if (s_pop) found = 1'b1;
      end
      checks++;
      if (!found || s_pop_pc !== want) begin
         errors++; $display("FAIL post_redirect: got found %0b pc %h want %h", found, s_pop_pc, want);
      end
   endtask

   task automatic test_redirect_coincident();
      lat = 1; rdy_pct = 100; idr_pct = 100;
      for (int i = 0; i < 6; i++) cycle();
      do_redirect = 1'b1; redir_target = 32'h0000_2468;
      cycle();
      checks++;
      if (s_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin
         errors++; $display("FAIL coincide_setup: got valid %0b rsp %0b want 1 1", s_valid, imem_rsp_valid);
      end
      wait_first_pop(32'h0000_2468);
      for (int i = 0; i < 3; i++) cycle();
      do_redirect = 1'b1; redir_target = 32'h0000_5000;
      cycle();
      do_redirect = 1'b1; redir_target = 32'h0000_6002;
      cycle();
      wait_first_pop(32'h0000_6000);
   endtask

   task automatic test_wrap();
      logic [31:0] p[2];
      int got = 0;
      lat = 1; rdy_pct = 100; idr_pct = 100;
      do_redirect = 1'b1; redir_target = 32'hFFFF_FFFC;
      cycle();
      for (int i = 0; i < 20 && got < 2; i++) begin
         cycle();
         if (s_pop) begin p[got] = s_pop_pc; got++; end
      end
      checks++;
      if (got != 2 || p[0] !== 32'hFFFF_FFFC || p[1] !== 32'h0000_0000) begin
         errors++; $display("FAIL wrap: got %0d pops %h %h want FFFFFFFC 00000000", got, p[0], p[1]);
      end
   endtask

   task automatic test_random();
      for (int b = 0; b < 4; b++) begin
         lat = $urandom_range(4, 1); rdy_pct = 70; idr_pct = 70;
         for (int i = 0; i < 100; i++) begin
            do_redirect  = ($urandom_range(99) < 5);
            redir_target = $urandom;
            cycle();
         end
      end
   endtask

   task automatic test_reset_midflight();
      int n0;
      lat = 2; rdy_pct = 100; idr_pct = 50;
      for (int i = 0; i < 5; i++) cycle();
      #3 reset = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP_INSTR ||
          id_pc !== 32'h0 || id_pcplus4 !== 32'h4) begin
         errors++; $display("FAIL async_reset: got rv%0b iv%0b %h %h %h want 0 0 %h 0 4",
                            imem_req_valid, id_valid, id_instr, id_pc, id_pcplus4, NOP_INSTR);
      end
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect = 1'b0;
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      mq_addr.delete(); mq_due.delete(); mq_epoch.delete();
      epoch++; buf_model = 0; exp_pop_pc = RPC; exp_fetch_pc = RPC; hold_pend = 1'b0;
      for (int i = 0; i < 3; i++) begin
         imem_req_ready = 1'b0; id_ready = 1'b1;
         imem_rsp_valid = 1'b1; imem_rsp_data = $urandom;
         #1;
         checks++;
         if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
            errors++; $display("FAIL stale_rsp: got iv%0b rv%0b %h want 0 1 %h", id_valid, imem_req_valid, imem_req_addr, RPC);
         end
         @(negedge clk);
         cyc++;
      end
      n0 = npops;
      lat = 1; rdy_pct = 100; idr_pct = 100;
      for (int i = 0; i < 10; i++) cycle();
      checks++;
      if (npops - n0 != 8) begin
         errors++; $display("FAIL restart: got %0d pops want 8", npops - n0);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_slow_mem();
      test_redirect_inflight();
      test_redirect_coincident();
      test_wrap();
      test_random();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the RV32I 5-stage pipeline. Replaces the bare PC register + adder + combinational imem with a PC generator and a ready/valid request/response memory port. Adds a small in-order prefetch buffer, stall back-pressure from ID, and branch/jump redirect with flush of in-flight fetches. Its outputs feed the IF/ID pipeline register directly.

## Interface
Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset
- BUF_DEPTH, 2, prefetch buffer entries; also max in-flight requests (power of 2, ≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; one clock, no other resets
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address (word aligned)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  instruction word returned (in order, ≤1 per cycle)
- imem_rsp_data  in  32  instruction word
- redirect  in  1  control-flow change from EX, one-cycle pulse
- redirect_pc  in  32  new fetch address
- id_ready  in  1  ID accepts instruction (low = stall)
- id_valid  out  1  id_instr/id_pc hold a real instruction
- id_instr  out  32  instruction, NOP 32'h00000013 when id_valid=0
- id_pc  out  32  PC of id_instr
- id_pcplus4  out  32  id_pc + 4

## Operation
- Registers: pc, buffer (BUF_DEPTH × {pc, instr}), pc-tag queue for in-flight requests, inflight counter, discard counter.
- pop = id_valid & id_ready & ~redirect.
- Issue: imem_req_valid = ~redirect & (buf_count + inflight − pop < BUF_DEPTH); imem_req_addr = pc.
- Accept (req_valid & req_ready): push pc into tag queue, inflight+1, pc <= pc + 4 (mod 2^32 wrap).
- Response: if discard>0, drop word, discard−1, inflight−1. Else pair with head tag, push {tag, data} into buffer, inflight−1.
- id_* outputs are driven from buffer head. When empty: id_valid=0, id_instr=NOP, id_pc=id_pcplus4−4 of last popped entry (don't-care).
- Redirect: pc <= {redirect_pc[31:2],2'b00}. Buffer and tag queue flushed. discard <= inflight − (rsp_valid this cycle ? 1:0) + discard adjustment, i.e. every word still owed is dropped. No request issued in redirect cycle.
- A request presented but not accepted may be withdrawn only by redirect. Otherwise addr and valid are held until ready.

## Timing
- Reset (async assert) values: pc=RESET_PC, buffer empty, inflight=0, discard=0, imem_req_valid=0, id_valid=0, id_instr=NOP, id_pc=0, id_pcplus4=4.
- First cycle after reset deassert: imem_req_valid=1, addr=RESET_PC.
- Latency with 1-cycle memory: request accepted cycle N, rsp at N+1, id_valid at N+2. Steady state is 1 instr/cycle with id_ready=1 and BUF_DEPTH=2.
- Buffer full and id_ready=0: no new requests; in-flight responses always have a slot (credit rule). Overflow is impossible.
- Simultaneous push and pop: both take effect, count unchanged.
- Redirect same cycle as rsp_valid: that word is dropped, not counted in discard.
- Redirect same cycle as id_ready=1: no pop. The entry is flushed.
- Back-to-back redirects: the second overrides, and discard accumulates correctly.
- Reset mid-flight: all state cleared. Memory responses arriving after reset deassert with inflight=0 are ignored.

## Structure
- Package fetch_pkg: XLEN=32, NOP_INSTR=32'h00000013, typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, async active-low reset. Instantiated for the buffer; the tag queue reuses it with instr unused.

## Test plan
- Reset, 1-cycle memory, id_ready=1 → id_pc sequence 0,4,8,… one per cycle from 2nd cycle after first accept, id_instr matches memory.
- id_ready low 5 cycles mid-stream → at most BUF_DEPTH requests outstanding+buffered, no entry lost or duplicated, resume at correct PC.
- Memory with 3-cycle latency and ready toggling → in-order delivery, addr held stable while req_valid & ~req_ready.
- Redirect to 32'h00000103 with 2 in flight → both late words dropped, next id_pc=32'h00000100.
- Redirect coincident with rsp_valid and id_ready → no pop, word dropped, first post-redirect id_valid is the target.
- pc at 32'hFFFFFFFC → next fetch 32'h00000000; async reset asserted mid-flight → outputs at reset values immediately.
